// File: rtl/riscv_trace_buffer.sv
// -----------------------------------------------------------------------------
// riscv_trace_buffer
//
// Commit-trace FIFO placed beside the RISC-V core. Each cycle it can capture
// up to two debug events from the core: one data-memory access (store or load)
// and one register write-back. Every event is tagged with the value of a
// free-running cycle timestamp and queued; a consumer drains the queue over a
// valid/ready port. Events that find no room are counted (saturating) and
// flagged with a sticky overflow bit. Capture can be frozen while draining
// continues.
//
// Ports
//   clk            clock
//   reset          synchronous, active-low reset
//   reg_write_sig  core register write strobe
//   reg_num        destination register number
//   reg_data       write-back value
//   wr / rd        data-memory write / read strobes (wr has priority)
//   addr           data-memory address
//   wr_data        store data
//   rd_data        load data
//   freeze         1: capture disabled, draining still allowed
//   clear_stats    clear drop_cnt and overflow
//   tr_valid       head entry valid
//   tr_ready       consumer accepts head
//   tr_kind        01 REG, 10 MEM_WR, 11 MEM_RD
//   tr_idx         register number (zero-extended) or memory address
//   tr_data        reg_data / wr_data / rd_data
//   tr_ts          timestamp of the capture cycle
//   level          current occupancy (0..DEPTH)
//   drop_cnt       dropped events, saturates at 16'hFFFF
//   overflow       sticky: at least one drop since reset/clear
// -----------------------------------------------------------------------------
module riscv_trace_buffer #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 9,
   parameter int DEPTH     = 16,
   parameter int TS_W      = 16,
   parameter int FILTER_X0 = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     reg_write_sig,
   input  logic [4:0]               reg_num,
   input  logic [DATA_W-1:0]        reg_data,
   input  logic                     wr,
   input  logic                     rd,
   input  logic [ADDR_W-1:0]        addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [DATA_W-1:0]        rd_data,
   input  logic                     freeze,
   input  logic                     clear_stats,
   output logic                     tr_valid,
   input  logic                     tr_ready,
   output logic [1:0]               tr_kind,
   output logic [ADDR_W-1:0]        tr_idx,
   output logic [DATA_W-1:0]        tr_data,
   output logic [TS_W-1:0]          tr_ts,
   output logic [$clog2(DEPTH):0]   level,
   output logic [15:0]              drop_cnt,
   output logic                     overflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = PTR_W + 1;

   localparam logic [1:0] KIND_REG    = 2'b01;
   localparam logic [1:0] KIND_MEM_WR = 2'b10;
   localparam logic [1:0] KIND_MEM_RD = 2'b11;

   // Entry storage; data path only, never reset.
   logic [1:0]        kind_mem [DEPTH];
   logic [ADDR_W-1:0] idx_mem  [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [TS_W-1:0]   ts_mem   [DEPTH];

   logic [PTR_W-1:0]  wptr;
   logic [PTR_W-1:0]  rptr;
   logic [TS_W-1:0]   ts;

   // Saturating add of the per-cycle drop count to the 16-bit drop counter.
   function automatic logic [15:0] sat_add16(input logic [15:0] cnt,
                                             input logic [1:0]  inc);
      logic [16:0] sum;
      sum = {1'b0, cnt} + {15'd0, inc};
      return sum[16] ? 16'hFFFF : sum[15:0];
   endfunction

   // Event decode and slot allocation
   logic              mem_ev;
   logic              reg_ev;
   logic [1:0]        mem_kind;
   logic [DATA_W-1:0] mem_data;
   logic [1:0]        n_ev;
   logic [1:0]        n_push;
   logic [1:0]        n_drop;
   logic [LVL_W-1:0]  free_slots;
   logic              pop;
   logic [1:0]        slot0_kind;
   logic [ADDR_W-1:0] slot0_idx;
   logic [DATA_W-1:0] slot0_data;
   logic [ADDR_W-1:0] reg_idx;

   always_comb begin
      mem_ev     = !freeze && (wr || rd);
      mem_kind   = wr ? KIND_MEM_WR : KIND_MEM_RD;
      mem_data   = wr ? wr_data : rd_data;
      reg_ev     = !freeze && reg_write_sig &&
                   !((FILTER_X0 != 0) && (reg_num == 5'd0));
      reg_idx    = ADDR_W'(reg_num);
      n_ev       = {1'b0, mem_ev} + {1'b0, reg_ev};
      // Space is judged on the pre-pop level: a same-cycle pop never makes
      // room for this cycle's events.
      free_slots = LVL_W'(DEPTH) - level;
      if (free_slots >= LVL_W'(2)) begin
         n_push = n_ev;
      end else if (free_slots == LVL_W'(1)) begin
         n_push = (n_ev != 2'd0) ? 2'd1 : 2'd0;
      end else begin
         n_push = 2'd0;
      end
      n_drop     = n_ev - n_push;
      pop        = tr_valid && tr_ready;
      // The memory event always takes the first slot so that a load is
      // queued ahead of its own write-back; the register event can only
      // ever be the one that loses out when a single slot remains.
      slot0_kind = mem_ev ? mem_kind : KIND_REG;
      slot0_idx  = mem_ev ? addr     : reg_idx;
      slot0_data = mem_ev ? mem_data : reg_data;
   end

   // Storage write
   always_ff @(posedge clk) begin
      if (n_push != 2'd0) begin
         kind_mem[wptr] <= slot0_kind;
         idx_mem[wptr]  <= slot0_idx;
         data_mem[wptr] <= slot0_data;
         ts_mem[wptr]   <= ts;
      end
      if (n_push == 2'd2) begin
         kind_mem[wptr + PTR_W'(1)] <= KIND_REG;
         idx_mem[wptr + PTR_W'(1)]  <= reg_idx;
         data_mem[wptr + PTR_W'(1)] <= reg_data;
         ts_mem[wptr + PTR_W'(1)]   <= ts;
      end
   end

   // Control state: pointers, occupancy, timestamp, statistics
   always_ff @(posedge clk) begin
      if (!reset) begin
         wptr     <= '0;
         rptr     <= '0;
         level    <= '0;
         ts       <= '0;
         drop_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         wptr  <= wptr + PTR_W'(n_push);
         rptr  <= rptr + PTR_W'(pop);
         level <= level + LVL_W'(n_push) - LVL_W'(pop);
         ts    <= ts + TS_W'(1);
         if (n_drop != 2'd0) begin
            // A drop in the same cycle as a clear restarts the count at
            // this cycle's drops rather than losing them.
            drop_cnt <= clear_stats ? {14'd0, n_drop} : sat_add16(drop_cnt, n_drop);
            overflow <= 1'b1;
         end else if (clear_stats) begin
            drop_cnt <= '0;
            overflow <= 1'b0;
         end
      end
   end

   // Head presentation; fields only move when rptr advances on a pop.
   assign tr_valid = (level != '0);
   assign tr_kind  = kind_mem[rptr];
   assign tr_idx   = idx_mem[rptr];
   assign tr_data  = data_mem[rptr];
   assign tr_ts    = ts_mem[rptr];

endmodule

// File: tb/tb_riscv_trace_buffer.sv
// -----------------------------------------------------------------------------
// tb_riscv_trace_buffer
//
// Bench for riscv_trace_buffer (DEPTH=4, TS_W=4 so fill and timestamp wrap
// are reached quickly). Expected entries are queued when events are driven
// and compared against the head when the DUT presents them; occupancy and
// drop statistics come from the same reference model.
// -----------------------------------------------------------------------------
module tb_riscv_trace_buffer;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 9;
   localparam int DEPTH  = 4;
   localparam int TS_W   = 4;

   logic              clk = 1'b0;
   logic              reset;
   logic              reg_write_sig;
   logic [4:0]        reg_num;
   logic [DATA_W-1:0] reg_data;
   logic              wr;
   logic              rd;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_data;
   logic              freeze;
   logic              clear_stats;
   logic              tr_valid;
   logic              tr_ready;
   logic [1:0]        tr_kind;
   logic [ADDR_W-1:0] tr_idx;
   logic [DATA_W-1:0] tr_data;
   logic [TS_W-1:0]   tr_ts;
   logic [2:0]        level;
   logic [15:0]       drop_cnt;
   logic              overflow;

   riscv_trace_buffer #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .TS_W(TS_W), .FILTER_X0(1)
   ) dut (
      .clk(clk), .reset(reset), .reg_write_sig(reg_write_sig), .reg_num(reg_num),
      .reg_data(reg_data), .wr(wr), .rd(rd), .addr(addr), .wr_data(wr_data),
      .rd_data(rd_data), .freeze(freeze), .clear_stats(clear_stats),
      .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_kind(tr_kind), .tr_idx(tr_idx),
      .tr_data(tr_data), .tr_ts(tr_ts), .level(level), .drop_cnt(drop_cnt),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]        kind;
      logic [ADDR_W-1:0] idx;
      logic [DATA_W-1:0] data;
      logic [TS_W-1:0]   ts;
   } ent_t;

   ent_t        sb_q[$];
   logic [15:0] drop_m;
   logic        ovf_m;
   logic [TS_W-1:0] ts_m;
   int          n_vec  = 0;
   int          n_miss = 0;

   task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      reg_write_sig = 1'b0;
      reg_num       = '0;
      reg_data      = '0;
      wr            = 1'b0;
      rd            = 1'b0;
      addr          = '0;
      wr_data       = '0;
      rd_data       = '0;
      freeze        = 1'b0;
      clear_stats   = 1'b0;
   endtask

   // Compare current outputs with the model, then advance model and DUT by
   // one clock using the inputs currently driven.
   task automatic step();
      ent_t e;
      int   free;
      int   ndrop;
      int   sum;
      chk_eq("valid", tr_valid, sb_q.size() != 0);
      chk_eq("level", level, sb_q.size());
      chk_eq("drop_cnt", drop_cnt, drop_m);
      chk_eq("overflow", overflow, ovf_m);
      if (sb_q.size() != 0) begin
         chk_eq("head_kind", tr_kind, sb_q[0].kind);
         chk_eq("head_idx", tr_idx, sb_q[0].idx);
         chk_eq("head_data", tr_data, sb_q[0].data);
         chk_eq("head_ts", tr_ts, sb_q[0].ts);
      end
      if (!reset) begin
         sb_q.delete();
         drop_m = '0;
         ovf_m  = 1'b0;
         ts_m   = '0;
      end else begin
         free  = DEPTH - sb_q.size();
         ndrop = 0;
         if (tr_ready && sb_q.size() != 0) void'(sb_q.pop_front());
         if (!freeze && (wr || rd)) begin
            e.kind = wr ? 2'b10 : 2'b11;
            e.idx  = addr;
            e.data = wr ? wr_data : rd_data;
            e.ts   = ts_m;
            if (free > 0) begin sb_q.push_back(e); free--; end
            else ndrop++;
         end
         if (!freeze && reg_write_sig && reg_num != 5'd0) begin
            e.kind = 2'b01;
            e.idx  = {4'd0, reg_num};
            e.data = reg_data;
            e.ts   = ts_m;
            if (free > 0) begin sb_q.push_back(e); free--; end
            else ndrop++;
         end
         if (ndrop != 0) begin
            sum    = clear_stats ? ndrop : int'(drop_m) + ndrop;
            drop_m = (sum > 65535) ? 16'hFFFF : 16'(sum);
            ovf_m  = 1'b1;
         end else if (clear_stats) begin
            drop_m = '0;
            ovf_m  = 1'b0;
         end
         ts_m = ts_m + 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic reg_ev(input logic [4:0] n, input logic [31:0] d);
      reg_write_sig = 1'b1;
      reg_num       = n;
      reg_data      = d;
   endtask

   initial begin
      idle();
      tr_ready = 1'b0;
      drop_m   = '0;
      ovf_m    = 1'b0;
      ts_m     = '0;
      // Reset with strobes active
      reset = 1'b0;
      reg_ev(5'd3, 32'h1111_1111);
      wr = 1'b1; addr = 9'h055; wr_data = 32'h2222;
      @(negedge clk);
      step();
      step();
      chk_eq("rst_valid", tr_valid, 1'b0);
      chk_eq("rst_level", level, 0);
      chk_eq("rst_drop", drop_cnt, 0);
      chk_eq("rst_ovf", overflow, 1'b0);
      reset = 1'b1;
      idle();
      // Current cycle has ts=0; an event in the next cycle carries ts=1
      step();
      reg_ev(5'd6, 32'hA5A5_0001);
      step();
      idle();
      chk_eq("ts_after_rst", tr_ts, 1);
      tr_ready = 1'b1;
      step();
      tr_ready = 1'b0;

      // Single register write captured at ts=3, held until accepted
      reg_ev(5'd5, 32'hDEADBEEF);
      step();
      idle();
      chk_eq("t2_valid", tr_valid, 1'b1);
      chk_eq("t2_kind", tr_kind, 2'b01);
      chk_eq("t2_idx", tr_idx, 5);
      chk_eq("t2_data", tr_data, 32'hDEADBEEF);
      chk_eq("t2_ts", tr_ts, 3);
      step();
      step();
      chk_eq("t2_hold", tr_data, 32'hDEADBEEF);
      tr_ready = 1'b1;
      step();
      tr_ready = 1'b0;
      chk_eq("t2_drained", level, 0);

      // Load and its write-back in one cycle: memory entry first
      rd = 1'b1; addr = 9'h010; rd_data = 32'h1234;
      reg_ev(5'd7, 32'h1234);
      step();
      idle();
      chk_eq("t3_level", level, 2);
      chk_eq("t3_kind0", tr_kind, 2'b11);
      chk_eq("t3_idx0", tr_idx, 9'h010);
      tr_ready = 1'b1;
      step();
      chk_eq("t3_kind1", tr_kind, 2'b01);
      chk_eq("t3_idx1", tr_idx, 7);
      step();
      tr_ready = 1'b0;

      // Fill to 3, then a dual event: store kept, write-back dropped
      for (int i = 1; i <= 3; i++) begin
         reg_ev(5'(i), 32'h100 + i);
         step();
      end
      idle();
      wr = 1'b1; rd = 1'b1; addr = 9'h1F0; wr_data = 32'hCAFE_0000;
      reg_ev(5'd4, 32'h104);
      step();
      idle();
      chk_eq("t4_level", level, 4);
      chk_eq("t4_drop", drop_cnt, 1);
      chk_eq("t4_ovf", overflow, 1'b1);
      reg_ev(5'd8, 32'h108);
      step();
      idle();
      chk_eq("t4_drop2", drop_cnt, 2);
      // Clear with a concurrent drop keeps this cycle's drop
      clear_stats = 1'b1;
      reg_ev(5'd9, 32'h109);
      step();
      idle();
      chk_eq("clr_drop", drop_cnt, 1);
      chk_eq("clr_ovf", overflow, 1'b1);
      clear_stats = 1'b1;
      step();
      idle();
      chk_eq("clr_only", drop_cnt, 0);

      // x0 filter and freeze
      tr_ready = 1'b1;
      step();
      tr_ready = 1'b0;
      reg_ev(5'd0, 32'hFFFF_FFFF);
      step();
      idle();
      chk_eq("x0_filtered", level, 3);
      freeze = 1'b1; wr = 1'b1; addr = 9'h022; wr_data = 32'h77;
      tr_ready = 1'b1;
      step();
      idle();
      tr_ready = 1'b0;
      chk_eq("freeze_drain", level, 2);

      // Simultaneous pop and single push at level 3
      reg_ev(5'd10, 32'h10A);
      step();
      reg_ev(5'd11, 32'h10B);
      tr_ready = 1'b1;
      step();
      idle();
      chk_eq("pop_push", level, 3);

      // Random traffic, includes timestamp wrap and full/empty cycling
      for (int i = 0; i < 300; i++) begin
         reg_write_sig = ($urandom_range(0, 3) != 0);
         reg_num       = 5'($urandom_range(0, 31));
         reg_data      = $urandom;
         wr            = ($urandom_range(0, 3) == 0);
         rd            = ($urandom_range(0, 2) == 0);
         addr          = 9'($urandom);
         wr_data       = $urandom;
         rd_data       = $urandom;
         freeze        = ($urandom_range(0, 15) == 0);
         clear_stats   = ($urandom_range(0, 31) == 0);
         tr_ready      = ($urandom_range(0, 2) != 0);
         step();
      end
      idle();

      // Reset while draining discards everything
      reg_ev(5'd12, 32'h10C);
      tr_ready = 1'b0;
      step();
      step();
      idle();
      tr_ready = 1'b1;
      reset    = 1'b0;
      step();
      reset = 1'b1;
      chk_eq("mid_rst_level", level, 0);
      chk_eq("mid_rst_valid", tr_valid, 1'b0);
      step();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
